// File: rtl/demux_pkg.sv
// Shared constants and channel state encoding for the 1-to-4 32-bit demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 32;
  localparam int unsigned DEMUX_NCH   = 4;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry holding register for a demux output channel: load wins over drain.
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEMUX_WIDTH,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  chan_state_t      state;
  logic [WIDTH-1:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CH_EMPTY;
      data  <= RST_DATA;
    end else if (load) begin
      // A load in the same cycle as a drain replaces the word and stays FULL.
      state <= CH_FULL;
      data  <= din;
    end else if (drain && state == CH_FULL) begin
      state <= CH_EMPTY;
    end
  end

  assign full = (state == CH_FULL);
  assign dout = data;

endmodule

// File: rtl/demux1t4_32_buf.sv
// Registered 1-to-4 demux for 32-bit words with per-channel one-entry buffers.
// Optional per-channel accept counters on port cnt when DEMUX1T4_CNT_EN is defined.
module demux1t4_32_buf
  import demux_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEMUX_WIDTH,
  parameter logic [WIDTH-1:0] RST_DATA = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       s,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3
`ifdef DEMUX1T4_CNT_EN
  ,
  output logic [31:0]      cnt
`endif
);

  logic [DEMUX_NCH-1:0] full;
  logic [DEMUX_NCH-1:0] load;
  logic [WIDTH-1:0]     chan_data [DEMUX_NCH];
  logic                 accept;

  // Head-of-line blocking is intentional: only the selected channel gates the input.
  assign in_ready = rst || !full[s] || out_ready[s];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < DEMUX_NCH; k++) begin
      load[k] = accept && (s == 2'(k));
    end
  end

  for (genvar g = 0; g < DEMUX_NCH; g++) begin : g_chan
    demux_chan_buf #(
      .WIDTH    (WIDTH),
      .RST_DATA (RST_DATA)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .drain (out_ready[g]),
      .din   (in_data),
      .full  (full[g]),
      .dout  (chan_data[g])
    );
  end

  assign out_valid = full;
  assign o0 = chan_data[0];
  assign o1 = chan_data[1];
  assign o2 = chan_data[2];
  assign o3 = chan_data[3];

`ifdef DEMUX1T4_CNT_EN
  logic [7:0] cnt_r [DEMUX_NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEMUX_NCH; k++) begin
        cnt_r[k] <= '0;
      end
    end else if (accept) begin
      cnt_r[s] <= cnt_r[s] + 8'd1;
    end
  end

  assign cnt = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
`endif

endmodule
